sonar_medidor_n: RTL and testbench
==================================

SONAR_MEDIDOR_N -- requirements
Module: sonar_medidor_n

Interface
REQ-001 The module SHALL have parameter N_DIGITOS, default 3, giving the number of BCD digits in the result.
REQ-002 The module SHALL have parameter CICLOS_TRIGGER, default 500, giving the trigger pulse width in clocks (10 us at 50 MHz).
REQ-003 The module SHALL have parameter CICLOS_POR_CM, default 2941, giving the echo clocks per centimetre.
REQ-004 The module SHALL have parameter CICLOS_TIMEOUT, default 1_500_000, giving the maximum clocks spent waiting for echo rise or during echo high.
REQ-005 The module SHALL have parameter CICLOS_INTERVALO, default 3_000_000, giving the gap between measurements in continuous mode.
REQ-006 The module SHALL have port clock, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port mensurar, input, 1 bit, level: starts a measurement.
REQ-009 The module SHALL have port continuo, input, 1 bit: continuous-mode enable.
REQ-010 The module SHALL have port echo, input, 1 bit: sensor echo, asynchronous to clock.
REQ-011 The module SHALL have port trigger, output, 1 bit: sensor trigger pulse.
REQ-012 The module SHALL have port medida, output, 4*N_DIGITOS bits: BCD distance in cm, least-significant digit in bits 3:0.
REQ-013 The module SHALL have port pronto, output, 1 bit: one-clock pulse when medida/flags update.
REQ-014 The module SHALL have port erro_timeout, output, 1 bit: the last measurement timed out.
REQ-015 The module SHALL have port fora_faixa, output, 1 bit: the last result saturated at all-nines.
REQ-016 The module SHALL have port db_estado, output, 4 bits: current FSM state encoding.

Function
REQ-017 The echo input SHALL pass through a two-flop synchroniser; all echo edge decisions SHALL use the synchronised value only.
REQ-018 The FSM SHALL have states INICIAL(0), PREPARA(1), TRIGGER(2), ESPERA_ECHO(3), MEDE(4), ARMAZENA(5), FINAL(6), INTERVALO(7).
REQ-019 In INICIAL, the FSM SHALL move to PREPARA when mensurar=1 or continuo=1.
REQ-020 In PREPARA (one clock), the FSM SHALL clear the tick counter, BCD counter, timeout counter and internal flags.
REQ-021 In TRIGGER, trigger SHALL be 1 for exactly CICLOS_TRIGGER clocks, after which the FSM SHALL go to ESPERA_ECHO.
REQ-022 In ESPERA_ECHO, a synchronised echo rise SHALL cause a transition to MEDE; CICLOS_TIMEOUT clocks without a rise SHALL set internal timeout and go to ARMAZENA.
REQ-023 In MEDE, the tick counter SHALL count to CICLOS_POR_CM-1, then wrap and increment the BCD counter by one.
REQ-024 In MEDE, a synchronised echo fall SHALL go to ARMAZENA; echo remaining high for CICLOS_TIMEOUT clocks SHALL set timeout and go to ARMAZENA.
REQ-025 Rounding: on echo fall, if the residual tick count is at least CICLOS_POR_CM/2 (integer division), the BCD counter SHALL increment once more.
REQ-026 The BCD counter SHALL carry digit-by-digit, and every increment SHALL be decimal-correct.
REQ-027 Saturation: an increment at all-nines SHALL leave the value at all-nines and set internal fora_faixa.
REQ-028 ARMAZENA (one clock) SHALL load medida, erro_timeout and fora_faixa from the internal values; on timeout, medida SHALL load all-nines.
REQ-029 FINAL SHALL assert pronto for exactly one clock.
REQ-030 From FINAL, the FSM SHALL go to INTERVALO if continuo=1, else to INICIAL.
REQ-031 INTERVALO SHALL wait CICLOS_INTERVALO clocks, then go to PREPARA if continuo=1, else to INICIAL.
REQ-032 continuo dropping mid-measurement SHALL NOT abort the measurement.
REQ-033 mensurar SHALL be ignored outside INICIAL.
REQ-034 mensurar held high SHALL cause back-to-back measurements.
REQ-035 medida, erro_timeout and fora_faixa SHALL hold their values between ARMAZENA events.
REQ-036 Latency from the synchronised echo fall to pronto SHALL be exactly 3 clocks: MEDE->ARMAZENA->FINAL.

Reset
REQ-037 reset=0 SHALL asynchronously force state INICIAL, trigger=0, pronto=0, medida=0, erro_timeout=0, fora_faixa=0, all counters to 0 and the synchroniser to 0.
REQ-038 Reset asserted mid-measurement, including while trigger is high, SHALL abort immediately with no pronto pulse.

Structure
REQ-039 The state encodings and default timing constants SHALL be defined in the shared package sonar_pkg.
REQ-040 The cascaded BCD counter SHALL be a sub-module contador_bcd_n with N_DIGITOS, clear, increment, saturation-flag and all-nines-detect functionality.

Verification
REQ-041 Bench: reset, mensurar pulse, echo rise 400 us after trigger, echo 5882 us high -> medida=0x100, pronto pulse, no flags.
REQ-042 Bench: echo 4430 us -> medida=0x075; echo 3222 us -> medida=0x055 (rounding up from 54.78).
REQ-043 Bench: no echo after trigger -> pronto after CICLOS_TIMEOUT, erro_timeout=1, medida=0x999.
REQ-044 Bench: with N_DIGITOS=2, echo 6000 us -> medida=0x99, fora_faixa=1.
REQ-045 Bench: continuo=1 with fixed 1000 us echoes -> successive pronto pulses spaced by trigger+wait+echo+CICLOS_INTERVALO+overhead, each with medida=0x017.
REQ-046 Bench: reset=0 during MEDE -> db_estado=0 and outputs zero immediately; a following measurement is correct.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic range meter: FSM state encoding,
// default timing constants (50 MHz clock) and small elaboration helpers.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        FINAL       = 4'd6,
        INTERVALO   = 4'd7
    } estado_t;

    localparam int DIGITOS_PADRAO   = 3;
    localparam int TRIGGER_PADRAO   = 500;
    localparam int POR_CM_PADRAO    = 2941;
    localparam int TIMEOUT_PADRAO   = 1_500_000;
    localparam int INTERVALO_PADRAO = 3_000_000;

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..n.
    function automatic int largura(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/contador_bcd_n.sv
// Cascaded N-digit BCD up-counter with synchronous clear, decimal carry
// and a sticky flag raised when an increment is attempted at all-nines.
module contador_bcd_n
    import sonar_pkg::*;
#(
    parameter int N_DIGITOS = DIGITOS_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   limpa,
    input  logic                   incrementa,
    output logic [4*N_DIGITOS-1:0] valor,
    output logic                   saturou
);

    localparam logic [4*N_DIGITOS-1:0] NOVES = {N_DIGITOS{4'h9}};

    logic [4*N_DIGITOS-1:0] proximo;
    logic                   todos_noves;

    assign todos_noves = (valor == NOVES);

    always_comb begin
        logic vai_um;
        vai_um  = 1'b1;
        proximo = valor;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (vai_um) begin
                if (valor[4*i +: 4] == 4'd9) begin
                    proximo[4*i +: 4] = 4'd0;
                end else begin
                    proximo[4*i +: 4] = valor[4*i +: 4] + 4'd1;
                    vai_um            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor   <= '0;
            saturou <= 1'b0;
        end else if (limpa) begin
            valor   <= '0;
            saturou <= 1'b0;
        end else if (incrementa) begin
            if (todos_noves) saturou <= 1'b1;
            else             valor   <= proximo;
        end
    end

endmodule

// File: rtl/sonar_medidor_n.sv
// Ultrasonic sonar controller: fires the trigger pulse, times the echo in
// centimetre ticks into a BCD result with rounding, saturation and timeout.
module sonar_medidor_n
    import sonar_pkg::*;
#(
    parameter int N_DIGITOS        = DIGITOS_PADRAO,
    parameter int CICLOS_TRIGGER   = TRIGGER_PADRAO,
    parameter int CICLOS_POR_CM    = POR_CM_PADRAO,
    parameter int CICLOS_TIMEOUT   = TIMEOUT_PADRAO,
    parameter int CICLOS_INTERVALO = INTERVALO_PADRAO
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mensurar,
    input  logic                   continuo,
    input  logic                   echo,
    output logic                   trigger,
    output logic [4*N_DIGITOS-1:0] medida,
    output logic                   pronto,
    output logic                   erro_timeout,
    output logic                   fora_faixa,
    output logic [3:0]             db_estado
);

    localparam int CNT_W  = largura(maximo(CICLOS_TRIGGER, maximo(CICLOS_TIMEOUT, CICLOS_INTERVALO)));
    localparam int TICK_W = largura(CICLOS_POR_CM);

    localparam logic [CNT_W-1:0]       FIM_TRIGGER   = CNT_W'(CICLOS_TRIGGER - 1);
    localparam logic [CNT_W-1:0]       FIM_TIMEOUT   = CNT_W'(CICLOS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]       FIM_INTERVALO = CNT_W'(CICLOS_INTERVALO - 1);
    localparam logic [TICK_W-1:0]      FIM_TICK      = TICK_W'(CICLOS_POR_CM - 1);
    localparam logic [TICK_W-1:0]      MEIO_CM       = TICK_W'(CICLOS_POR_CM / 2);
    localparam logic [4*N_DIGITOS-1:0] NOVES         = {N_DIGITOS{4'h9}};

    estado_t                estado, proximo;
    logic                   echo_p0, echo_p1, echo_p2;
    logic                   subida, descida;
    logic [CNT_W-1:0]       cnt;
    logic [TICK_W-1:0]      tick;
    logic                   timeout_int;
    logic                   limpa, zera_cnt, tick_um, avanca_tick;
    logic                   inc_bcd, marca_timeout, armazena;
    logic [4*N_DIGITOS-1:0] bcd_valor;
    logic                   bcd_saturou;

    // Stage p0/p1: two-flop synchroniser; p2 holds the previous synced value for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_p0 <= 1'b0;
            echo_p1 <= 1'b0;
            echo_p2 <= 1'b0;
        end else begin
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;
        end
    end

    assign subida  =  echo_p1 & ~echo_p2;
    assign descida = ~echo_p1 &  echo_p2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo       = estado;
        limpa         = 1'b0;
        zera_cnt      = 1'b0;
        tick_um       = 1'b0;
        avanca_tick   = 1'b0;
        inc_bcd       = 1'b0;
        marca_timeout = 1'b0;
        armazena      = 1'b0;
        unique case (estado)
            INICIAL: begin
                if (mensurar || continuo) proximo = PREPARA;
            end
            PREPARA: begin
                limpa    = 1'b1;
                zera_cnt = 1'b1;
                proximo  = TRIGGER;
            end
            TRIGGER: begin
                if (cnt == FIM_TRIGGER) begin
                    zera_cnt = 1'b1;
                    proximo  = ESPERA_ECHO;
                end
            end
            ESPERA_ECHO: begin
                // The rise cycle is already one echo-high clock, so ticks start at 1
                if (subida) begin
                    zera_cnt = 1'b1;
                    tick_um  = 1'b1;
                    proximo  = MEDE;
                end else if (cnt == FIM_TIMEOUT) begin
                    marca_timeout = 1'b1;
                    proximo       = ARMAZENA;
                end
            end
            MEDE: begin
                if (descida) begin
                    inc_bcd = (tick >= MEIO_CM);
                    proximo = ARMAZENA;
                end else if (cnt == FIM_TIMEOUT) begin
                    marca_timeout = 1'b1;
                    proximo       = ARMAZENA;
                end else begin
                    avanca_tick = 1'b1;
                    inc_bcd     = (tick == FIM_TICK);
                end
            end
            ARMAZENA: begin
                armazena = 1'b1;
                proximo  = FINAL;
            end
            FINAL: begin
                zera_cnt = 1'b1;
                proximo  = continuo ? INTERVALO : INICIAL;
            end
            INTERVALO: begin
                if (cnt == FIM_INTERVALO) proximo = continuo ? PREPARA : INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                                    cnt <= '0;
        else if (zera_cnt)                                             cnt <= '0;
        else if (estado inside {TRIGGER, ESPERA_ECHO, MEDE, INTERVALO}) cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           tick <= '0;
        else if (limpa)       tick <= '0;
        else if (tick_um)     tick <= TICK_W'(1);
        else if (avanca_tick) tick <= (tick == FIM_TICK) ? '0 : tick + TICK_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              timeout_int <= 1'b0;
        else if (limpa)          timeout_int <= 1'b0;
        else if (marca_timeout)  timeout_int <= 1'b1;
    end

    contador_bcd_n #(
        .N_DIGITOS (N_DIGITOS)
    ) u_contador (
        .clock      (clock),
        .reset      (reset),
        .limpa      (limpa),
        .incrementa (inc_bcd),
        .valor      (bcd_valor),
        .saturou    (bcd_saturou)
    );

    // Registered from the next state so trigger/pronto are glitch-free and aligned with the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trigger      <= 1'b0;
            pronto       <= 1'b0;
            medida       <= '0;
            erro_timeout <= 1'b0;
            fora_faixa   <= 1'b0;
        end else begin
            trigger <= (proximo == TRIGGER);
            pronto  <= (proximo == FINAL);
            if (armazena) begin
                medida       <= timeout_int ? NOVES : bcd_valor;
                erro_timeout <= timeout_int;
                fora_faixa   <= bcd_saturou;
            end
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_sonar_medidor_n.sv
// Scoreboard bench for sonar_medidor_n with scaled timing constants: a
// 3-digit and a 2-digit instance, checked against a distance-rounding model.
module tb_sonar_medidor_n;

    localparam int TRIG = 5;
    localparam int CPC  = 29;
    localparam int TMO  = 4000;
    localparam int INTV = 200;

    typedef struct {
        logic [15:0] medida;
        logic        to;
        logic        ff;
    } esperado_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        mens_v[2];
    logic        cont_v[2];
    logic        echo_v[2];
    logic        trig0, trig1, pronto0, pronto1, to0, to1, ff0, ff1;
    logic [3:0]  est0, est1;
    logic [11:0] med0;
    logic [7:0]  med1;

    esperado_t q0[$];
    esperado_t q1[$];
    esperado_t e_mon0, e_mon1;
    logic      p0_ant = 1'b0;
    logic      p1_ant = 1'b0;
    int        checks = 0;
    int        errors = 0;
    int        ciclo  = 0;
    int        t_pronto = 0;

    always #5 clock = ~clock;
    always @(posedge clock) ciclo++;

    sonar_medidor_n #(
        .N_DIGITOS(3), .CICLOS_TRIGGER(TRIG), .CICLOS_POR_CM(CPC),
        .CICLOS_TIMEOUT(TMO), .CICLOS_INTERVALO(INTV)
    ) dut0 (
        .clock(clock), .reset(rst_n), .mensurar(mens_v[0]), .continuo(cont_v[0]),
        .echo(echo_v[0]), .trigger(trig0), .medida(med0), .pronto(pronto0),
        .erro_timeout(to0), .fora_faixa(ff0), .db_estado(est0)
    );

    sonar_medidor_n #(
        .N_DIGITOS(2), .CICLOS_TRIGGER(TRIG), .CICLOS_POR_CM(CPC),
        .CICLOS_TIMEOUT(TMO), .CICLOS_INTERVALO(INTV)
    ) dut1 (
        .clock(clock), .reset(rst_n), .mensurar(mens_v[1]), .continuo(cont_v[1]),
        .echo(echo_v[1]), .trigger(trig1), .medida(med1), .pronto(pronto1),
        .erro_timeout(to1), .fora_faixa(ff1), .db_estado(est1)
    );

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
        end
    endtask

    function automatic logic trg(input int u);
        return (u == 0) ? trig0 : trig1;
    endfunction

    function automatic logic prt(input int u);
        return (u == 0) ? pronto0 : pronto1;
    endfunction

    // Distance in cm = echo-high clocks / clocks-per-cm, rounded half up, clipped to all-nines.
    function automatic esperado_t modelo(input int ciclos, input int nd, input bit timeout);
        esperado_t e;
        int cm, lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim *= 10;
        lim--;
        cm = ciclos / CPC;
        if ((ciclos % CPC) >= CPC / 2) cm++;
        e.ff = (cm > lim);
        if (cm > lim) cm = lim;
        if (timeout) begin
            cm   = lim;
            e.ff = 1'b0;
        end
        e.to     = timeout;
        e.medida = '0;
        for (int i = 0; i < nd; i++) begin
            e.medida[4*i +: 4] = 4'(cm % 10);
            cm = cm / 10;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (rst_n && pronto0) begin
            chk("pronto0_largura", 32'(p0_ant), 0);
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pronto0_inesperado: got pronto with medida 0x%0h, expected no pronto", med0);
            end else begin
                e_mon0 = q0.pop_front();
                chk("medida0", 32'(med0), 32'(e_mon0.medida[11:0]));
                chk("erro_timeout0", 32'(to0), 32'(e_mon0.to));
                chk("fora_faixa0", 32'(ff0), 32'(e_mon0.ff));
            end
        end
        p0_ant = rst_n & pronto0;
    end

    always @(negedge clock) begin
        if (rst_n && pronto1) begin
            chk("pronto1_largura", 32'(p1_ant), 0);
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pronto1_inesperado: got pronto with medida 0x%0h, expected no pronto", med1);
            end else begin
                e_mon1 = q1.pop_front();
                chk("medida1", 32'(med1), 32'(e_mon1.medida[7:0]));
                chk("erro_timeout1", 32'(to1), 32'(e_mon1.to));
                chk("fora_faixa1", 32'(ff1), 32'(e_mon1.ff));
            end
        end
        p1_ant = rst_n & pronto1;
    end

    // One full measurement on instance u; expectation is queued once the trigger starts.
    task automatic medir(input int u, input int h, input int atraso, input bit sem_echo,
                         input bit por_cont, input bit solta_cont);
        int n;
        esperado_t e;
        e = modelo(h, (u == 0) ? 3 : 2, sem_echo);
        if (!por_cont) mens_v[u] = 1'b1;
        n = 0;
        while (!trg(u) && n < INTV + 50) begin
            @(negedge clock);
            n++;
        end
        chk("trigger_sobe", 32'(trg(u)), 1);
        mens_v[u] = 1'b0;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        n = 0;
        while (trg(u) && n < TRIG + 10) begin
            n++;
            @(negedge clock);
        end
        chk("largura_trigger", 32'(n), 32'(TRIG));
        if (!sem_echo) begin
            repeat (atraso) @(negedge clock);
            echo_v[u] = 1'b1;
            if (solta_cont) begin
                repeat (h / 2) @(negedge clock);
                cont_v[u] = 1'b0;
                repeat (h - h / 2) @(negedge clock);
            end else begin
                repeat (h) @(negedge clock);
            end
            echo_v[u] = 1'b0;
        end
        n = 0;
        while (!prt(u) && n < TMO + 20) begin
            @(negedge clock);
            n++;
        end
        if (sem_echo) chk("latencia_timeout", 32'(n), 32'(TMO + 1));
        else          chk("latencia_pronto", 32'(n), 4);
        t_pronto = ciclo;
        @(negedge clock);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int n, t0, d, lo, h;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mens_v[u] = 1'b0;
            cont_v[u] = 1'b0;
            echo_v[u] = 1'b0;
        end
        repeat (3) @(negedge clock);
        chk("reset_estado", 32'(est0), 0);
        chk("reset_trigger", 32'(trig0), 0);
        chk("reset_pronto", 32'(pronto0), 0);
        chk("reset_medida", 32'(med0), 0);
        chk("reset_erro", 32'(to0), 0);
        chk("reset_fora", 32'(ff0), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        medir(0, 100 * CPC, 20, 0, 0, 0);       // 100 cm
        medir(0, 2184, 7, 0, 0, 0);             // 75.31 cm
        medir(0, 1589, 3, 0, 0, 0);             // 54.79 cm rounds to 55
        medir(0, 20 * CPC + 14, 0, 0, 0, 0);    // residual exactly at half
        medir(0, 20 * CPC + 13, 0, 0, 0, 0);    // residual just below half
        medir(0, 1, 2, 0, 0, 0);                // one-clock echo

        medir(0, 0, 0, 1, 0, 0);                // no echo
        repeat (30) @(negedge clock);
        chk("medida_retida", 32'(med0), 32'h999);
        chk("erro_retido", 32'(to0), 1);

        for (int k = 0; k < 8; k++) begin
            h = int'($urandom_range(2000, 1));
            medir(0, h, int'($urandom_range(500, 0)), 0, 0, 0);
        end

        medir(0, 100 * CPC, 5, 0, 0, 0);
        mens_v[0] = 1'b1;
        n = 0;
        while (!trig0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("reset_trigger_trigger", 32'(trig0), 0);
        chk("reset_trigger_estado", 32'(est0), 0);
        mens_v[0] = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        medir(0, 100 * CPC, 5, 0, 0, 0);
        mens_v[0] = 1'b1;
        n = 0;
        while (!trig0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        mens_v[0] = 1'b0;
        n = 0;
        while (trig0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        echo_v[0] = 1'b1;
        repeat (40) @(negedge clock);
        chk("estado_mede", 32'(est0), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mede_estado", 32'(est0), 0);
        chk("reset_mede_trigger", 32'(trig0), 0);
        chk("reset_mede_pronto", 32'(pronto0), 0);
        chk("reset_mede_medida", 32'(med0), 0);
        chk("reset_mede_erro", 32'(to0), 0);
        chk("reset_mede_fora", 32'(ff0), 0);
        echo_v[0] = 1'b0;
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        medir(0, 1000, 9, 0, 0, 0);

        medir(1, 120 * CPC, 5, 0, 0, 0);        // 120 cm on two digits
        medir(1, 99 * CPC + 14, 5, 0, 0, 0);    // rounding step hits saturation
        medir(1, 99 * CPC + 13, 5, 0, 0, 0);    // 99 cm, flag cleared again
        medir(1, 42 * CPC + 2, 5, 0, 0, 0);

        h  = 17 * CPC + 3;
        lo = INTV + TRIG + h;
        cont_v[0] = 1'b1;
        medir(0, h, 10, 0, 1, 0);
        t0 = t_pronto;
        medir(0, h, 10, 0, 1, 0);
        d = t_pronto - t0;
        chk("espaco_pronto_1", 32'(d >= lo && d <= lo + 25), 1);
        t0 = t_pronto;
        medir(0, h, 10, 0, 1, 1);
        d = t_pronto - t0;
        chk("espaco_pronto_2", 32'(d >= lo && d <= lo + 25), 1);
        repeat (2) @(negedge clock);
        chk("continuo_parado_estado", 32'(est0), 0);
        n = 0;
        repeat (INTV + 20) begin
            @(negedge clock);
            if (trig0) n++;
        end
        chk("continuo_parado_trigger", 32'(n), 0);

        chk("fila0_vazia", 32'(q0.size()), 0);
        chk("fila1_vazia", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
